// File: rtl/fft_tx_out.sv
// FFT output stage: frame-wide shift/round/saturate, IFFT conjugate, small FIFO, ready/valid out.
// Optional saturation statistics are built only when FFT_TX_STATS_EN is defined.
module fft_tx_out #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cont_ifft,
  input  logic [3:0]       cont_point,
  input  logic [4:0]       cont_final_shift,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_re,
  input  logic [IN_W-1:0]  in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_re,
  output logic [OUT_W-1:0] out_im,
  output logic             out_last,
  output logic             tx_done,
  output logic [15:0]      sat_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_L = (PTR_W+2)'(DEPTH);
  localparam logic [4:0] SHIFT_MAX = 5'(IN_W-1);
  localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  function automatic logic signed [IN_W:0] round_shift(input logic [IN_W-1:0] x,
                                                      input logic [4:0] s);
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] rnd;
    ext = $signed({x[IN_W-1], x});
    rnd = '0;
    if (s != 5'd0) rnd = (IN_W+1)'(1) << (s - 5'd1);
    return (ext + rnd) >>> s;
  endfunction

  function automatic logic [OUT_W-1:0] clip(input logic signed [IN_W:0] r);
    if (r > SAT_MAX)      return OUT_MAX;
    else if (r < SAT_MIN) return OUT_MIN;
    else                  return r[OUT_W-1:0];
  endfunction

  logic                    stage_valid_q, stage_valid_d;
  logic [OUT_W-1:0]        stage_re_q, stage_re_d;
  logic [OUT_W-1:0]        stage_im_q, stage_im_d;
  logic                    stage_last_q, stage_last_d;
  logic [9:0]              in_cnt_q, in_cnt_d;
  logic                    cfg_ifft_q, cfg_ifft_d;
  logic [3:0]              cfg_point_q, cfg_point_d;
  logic [4:0]              cfg_shift_q, cfg_shift_d;
  logic [PTR_W:0]          fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [2*OUT_W:0]        mem_q [DEPTH];

  logic                    accept, frame_start, last_hit, eff_ifft, fifo_rd;
  logic [3:0]              eff_point;
  logic [4:0]              eff_shift;
  logic signed [IN_W:0]    re_r, im_r;
  logic [OUT_W-1:0]        re_s, im_s;
  logic [PTR_W+1:0]        occupancy;
  logic [2*OUT_W:0]        head;

  // Stage + FIFO occupancy gates acceptance, so neither the stage nor the FIFO write can stall.
  assign occupancy = {1'b0, fifo_cnt_q} + {{(PTR_W+1){1'b0}}, stage_valid_q};
  assign in_ready  = rst_n && (occupancy < DEPTH_L);
  assign accept    = in_valid && in_ready;
  assign out_valid = (fifo_cnt_q != '0);
  assign fifo_rd   = out_valid && out_ready;
  assign tx_done   = fifo_rd;
  assign head      = mem_q[rd_ptr_q];
  assign out_re    = out_valid ? head[2*OUT_W:OUT_W+1] : '0;
  assign out_im    = out_valid ? head[OUT_W:1] : '0;
  assign out_last  = out_valid && head[0];

  always_comb begin
    frame_start = (in_cnt_q == '0);
    // First sample of a frame uses the live config; the rest use the latched copy.
    eff_ifft    = frame_start ? cont_ifft : cfg_ifft_q;
    eff_point   = frame_start ? ((cont_point > 4'd10) ? 4'd10 : cont_point) : cfg_point_q;
    eff_shift   = frame_start ? ((cont_final_shift > SHIFT_MAX) ? SHIFT_MAX : cont_final_shift)
                              : cfg_shift_q;
    last_hit    = ({1'b0, in_cnt_q} == ((11'd1 << eff_point) - 11'd1));

    re_r = round_shift(in_re, eff_shift);
    im_r = round_shift(in_im, eff_shift);
    re_s = clip(re_r);
    im_s = clip(im_r);

    stage_valid_d = accept;
    stage_re_d    = stage_re_q;
    stage_im_d    = stage_im_q;
    stage_last_d  = stage_last_q;
    in_cnt_d      = in_cnt_q;
    cfg_ifft_d    = cfg_ifft_q;
    cfg_point_d   = cfg_point_q;
    cfg_shift_d   = cfg_shift_q;
    if (accept) begin
      stage_re_d   = re_s;
      stage_im_d   = eff_ifft ? ((im_s == OUT_MIN) ? OUT_MAX : -im_s) : im_s;
      stage_last_d = last_hit;
      in_cnt_d     = last_hit ? '0 : in_cnt_q + 10'd1;
      cfg_ifft_d   = eff_ifft;
      cfg_point_d  = eff_point;
      cfg_shift_d  = eff_shift;
    end

    wr_ptr_d = stage_valid_q ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = fifo_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({stage_valid_q, fifo_rd})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid_q <= 1'b0;
      stage_re_q    <= '0;
      stage_im_q    <= '0;
      stage_last_q  <= 1'b0;
      in_cnt_q      <= '0;
      cfg_ifft_q    <= 1'b0;
      cfg_point_q   <= '0;
      cfg_shift_q   <= '0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_re_q    <= stage_re_d;
      stage_im_q    <= stage_im_d;
      stage_last_q  <= stage_last_d;
      in_cnt_q      <= in_cnt_d;
      cfg_ifft_q    <= cfg_ifft_d;
      cfg_point_q   <= cfg_point_d;
      cfg_shift_q   <= cfg_shift_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && stage_valid_q) mem_q[wr_ptr_q] <= {stage_re_q, stage_im_q, stage_last_q};
  end

`ifdef FFT_TX_STATS_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic        sat_evt;

  // The IFFT negation clamp of -2^(OUT_W-1) counts as a saturation too.
  always_comb begin
    sat_evt = (re_r > SAT_MAX) || (re_r < SAT_MIN) || (im_r > SAT_MAX) || (im_r < SAT_MIN) ||
              (eff_ifft && (im_s == OUT_MIN));
    sat_cnt_d = sat_cnt_q;
    if (accept && sat_evt && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_fft_tx_out.sv
// Self-checking bench for fft_tx_out: constant vector table, directed sequences and
// randomized traffic against an arithmetic reference model with a sample queue.
module tb_fft_tx_out;

  localparam int IN_W  = 24;
  localparam int OUT_W = 16;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cont_ifft;
  logic [3:0]        cont_point;
  logic [4:0]        cont_final_shift;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_re, in_im;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_re, out_im;
  logic              out_last;
  logic              tx_done;
  logic [15:0]       sat_count;

  fft_tx_out #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cont_ifft(cont_ifft), .cont_point(cont_point),
    .cont_final_shift(cont_final_shift), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_last(out_last), .tx_done(tx_done),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { longint re; longint im; bit last; longint avail; } exp_t;
  exp_t   q[$];
  longint edge_cnt = 0;
  int     fcnt = 0;
  bit     m_ifft;
  int     m_point, m_sh;
  longint msat = 0;
  int     tx_cnt = 0, last_cnt = 0;

  function automatic longint floordiv(longint a, longint b);
    longint r;
    r = a / b;
    if ((a % b != 0) && (a < 0)) r = r - 1;
    return r;
  endfunction

  function automatic longint scale(longint x, int sh);
    longint d;
    if (sh == 0) return x;
    d = longint'(1) << sh;
    return floordiv(x + d / 2, d);
  endfunction

  function automatic longint clamp16(longint v, inout bit sat);
    if (v > 32767)  begin sat = 1; return 32767;  end
    if (v < -32768) begin sat = 1; return -32768; end
    return v;
  endfunction

  function automatic void model_push(logic [IN_W-1:0] re, logic [IN_W-1:0] im);
    exp_t e;
    bit   sat;
    if (fcnt == 0) begin
      m_ifft  = cont_ifft;
      m_point = (cont_point > 10) ? 10 : int'(cont_point);
      m_sh    = (cont_final_shift > IN_W - 1) ? IN_W - 1 : int'(cont_final_shift);
    end
    sat  = 0;
    e.re = clamp16(scale(longint'($signed(re)), m_sh), sat);
    e.im = clamp16(scale(longint'($signed(im)), m_sh), sat);
    if (m_ifft) e.im = clamp16(-e.im, sat);
    e.last  = (fcnt == (1 << m_point) - 1);
    e.avail = edge_cnt + 2;
    fcnt    = e.last ? 0 : fcnt + 1;
    if (sat && msat < 65535) msat++;
    q.push_back(e);
  endfunction

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    bit ev, rdy;
    if (!rst_n) begin
      q.delete();
      fcnt = 0;
      msat = 0;
    end else begin
      ev  = (q.size() > 0) && (q[0].avail <= edge_cnt);
      rdy = (q.size() < DEPTH);
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, rdy);
      chk("tx_done", tx_done, ev && out_ready);
      if (tx_done) begin
        tx_cnt++;
        if (out_last) last_cnt++;
      end
      if (ev) begin
        chk("out_re", longint'($signed(out_re)), q[0].re);
        chk("out_im", longint'($signed(out_im)), q[0].im);
        chk("out_last", out_last, q[0].last);
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && rdy) model_push(in_re, in_im);
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [IN_W-1:0] re, im;
    logic [4:0]      sh;
    logic            ifft;
    int              exp_re, exp_im;
  } vec_t;
  vec_t tbl[9];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sat(input string name);
`ifdef FFT_TX_STATS_EN
    chk(name, sat_count, msat);
`else
    chk(name, sat_count, 0);
`endif
  endtask

  initial begin
    int acc, t0, l0;
    tbl[0] = '{24'd24,        24'd0,          5'd4,  1'b0, 2,      0};
    tbl[1] = '{24'(-24),      24'd0,          5'd4,  1'b0, -1,     0};
    tbl[2] = '{24'h7FFFFF,    24'd0,          5'd4,  1'b0, 32767,  0};
    tbl[3] = '{24'd0,         24'h800000,     5'd8,  1'b1, 0,      32767};
    tbl[4] = '{24'h000100,    24'h000100,     5'd8,  1'b1, 1,      -1};
    tbl[5] = '{24'h7FFFFF,    24'h800000,     5'd31, 1'b0, 1,      -1};
    tbl[6] = '{24'(-40000),   24'd40000,      5'd0,  1'b0, -32768, 32767};
    tbl[7] = '{24'd3,         24'(-3),        5'd1,  1'b1, 2,      1};
    tbl[8] = '{24'(-1),       24'd1,          5'd1,  1'b0, 0,      1};

    rst_n = 0; in_valid = 0; out_ready = 0; in_re = '0; in_im = '0;
    cont_ifft = 0; cont_point = 4'd0; cont_final_shift = 5'd0;
    repeat (3) cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready_low", in_ready, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_sat", sat_count, 0);
    rst_n = 1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_last", out_last, 0);
    chk("rst_tx_done", tx_done, 0);

    // Frame of 8, re=k, im=-k, with latency check
    cont_point = 4'd3; cont_final_shift = 5'd0; cont_ifft = 0; out_ready = 1;
    t0 = tx_cnt; l0 = last_cnt;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1; in_re = 24'(k); in_im = 24'(-k);
      cyc();
      if (k == 1) chk("lat_edge1_valid", out_valid, 0);
      if (k == 2) chk("lat_edge2_valid", out_valid, 1);
    end
    in_valid = 0;
    repeat (4) cyc();
    chk("f8_tx_pulses", tx_cnt - t0, 8);
    chk("f8_last_pulses", last_cnt - l0, 1);

    // Vector table, point 0 so every sample is its own frame
    cont_point = 4'd0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; in_re = tbl[i].re; in_im = tbl[i].im;
      cont_final_shift = tbl[i].sh; cont_ifft = tbl[i].ifft;
      cyc();
      in_valid = 0;
      cyc();
      chk("tbl_valid", out_valid, 1);
      chk("tbl_re", longint'($signed(out_re)), tbl[i].exp_re);
      chk("tbl_im", longint'($signed(out_im)), tbl[i].exp_im);
      chk("tbl_last", out_last, 1);
      cyc();
    end
    check_sat("tbl_sat_count");

    // Backpressure: frame of 4 fills the buffer exactly
    cont_point = 4'd2; cont_final_shift = 5'd2; cont_ifft = 0; out_ready = 0;
    acc = 0; t0 = tx_cnt;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1; in_re = 24'($urandom()); in_im = 24'($urandom());
      if (in_ready) acc++;
      cyc();
    end
    chk("bp_accepts", acc, DEPTH);
    chk("bp_in_ready_low", in_ready, 0);
    in_valid = 0; out_ready = 1;
    cyc();
    chk("bp_in_ready_rise", in_ready, 1);
    repeat (5) cyc();
    chk("bp_drained", tx_cnt - t0, DEPTH);

    // Mid-frame config change is ignored until the next frame
    cont_point = 4'd3; cont_final_shift = 5'd0; l0 = last_cnt;
    for (int k = 0; k < 12; k++) begin
      in_valid = 1; in_re = 24'(k * 100); in_im = 24'(k);
      if (k == 3) cont_point = 4'd2;
      cyc();
    end
    in_valid = 0;
    repeat (4) cyc();
    chk("midcfg_lasts", last_cnt - l0, 2);

    // Reset with samples buffered
    cont_point = 4'd3; out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_re = 24'h7FFFFF; in_im = 24'(k);
      cont_final_shift = 5'd0;
      cyc();
    end
    in_valid = 0;
    repeat (2) cyc();
    rst_n = 0;
    cyc();
    rst_n = 1;
    out_ready = 1;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_sat", sat_count, 0);
    chk("mrst_tx_done", tx_done, 0);
    l0 = last_cnt;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1; in_re = 24'(k); in_im = 24'(k);
      cyc();
    end
    in_valid = 0;
    repeat (4) cyc();
    chk("mrst_lasts", last_cnt - l0, 1);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      int pick;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      pick = $urandom_range(0, 7);
      in_re = (pick == 0) ? 24'h7FFFFF : (pick == 1) ? 24'h800000 : 24'($urandom());
      pick = $urandom_range(0, 7);
      in_im = (pick == 0) ? 24'h7FFFFF : (pick == 1) ? 24'h800000 : 24'($urandom());
      cont_ifft = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 5);
      cont_point = (pick == 5) ? 4'd12 : 4'(pick);
      cont_final_shift = 5'($urandom_range(0, 31));
      cyc();
    end
    in_valid = 0; out_ready = 1;
    repeat (10) cyc();
    chk("drain_empty", out_valid, 0);
    check_sat("final_sat_count");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_tx_out.md
# fft_tx_out

Output stage of the FFT datapath, directly downstream of the compute core. Takes full-precision butterfly results, applies the frame's final right-shift with rounding and saturation, and conjugates for IFFT. It buffers samples in a small FIFO and presents them to the host side over a ready/valid stream with per-frame `last`. It reports each delivered sample to the controller so the controller's in-flight sample count decrements.

## Interface
Parameters:
- IN_W, 24, width of each input real/imag component (signed)
- OUT_W, 16, width of each output real/imag component (signed)
- DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cont_ifft  in  1  1 = IFFT mode, conjugate output
- cont_point  in  4  log2 frame length; valid 0..10, values >10 treated as 10
- cont_final_shift  in  5  arithmetic right shift; values >IN_W-1 treated as IN_W-1
- in_valid  in  1  compute core sample valid
- in_ready  out  1  stage can accept a sample
- in_re, in_im  in  IN_W  signed sample
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts
- out_re, out_im  out  OUT_W  signed result
- out_last  out  1  final sample of frame
- tx_done  out  1  one-cycle pulse per delivered sample (to controller)
- sat_count  out  16  saturation event counter (see Configuration)

## Operation
- Input handshake: sample accepted on a rising edge where in_valid && in_ready.
- in_ready = (fifo_count + stage_valid) < DEPTH, combinational; 0 while rst_n = 0.
- Frame tracking: in_cnt (10 bits) counts accepted inputs. On acceptance with in_cnt == 0, cont_ifft, cont_point and cont_final_shift are latched and used for the whole frame; mid-frame changes on cont_* are ignored.
- The last tag is set when in_cnt == 2^point − 1, and in_cnt then wraps to 0. For point 0, every sample is last.
- Stage register, one cycle:
  - s = clamped shift.
  - Rounded value r = (x + (s>0 ? 2^(s−1) : 0)) >>> s, computed in IN_W+1 bits (round half up, arithmetic shift).
  - Saturate r to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - If ifft: out_im = −sat(im); −(−32768) saturates to 32767. Real part is untouched.
- The stage writes {re, im, last} into the FIFO on the next edge. Stage and FIFO write never stall, because in_ready reserves space.
- out_valid = FIFO not empty; out_re/out_im/out_last come from the FIFO head. The head holds stable while out_valid && !out_ready.
- tx_done = out_valid && out_ready, combinational, same cycle as the output handshake.
- Simultaneous FIFO write and read while full or empty: both occur, and the count is unchanged.

## Timing
- Reset (rst_n low at a clock edge) clears FIFO, stage, in_cnt, latched config and sat_count.
  - Outputs after reset: out_valid 0, out_last 0, out_re/out_im 0, tx_done 0, sat_count 0, in_ready 1.
  - Reset mid-frame discards all buffered samples; the next accepted sample starts a new frame.
- Latency: a sample accepted at edge N is in the stage after N and in the FIFO after N+1, so out_valid is high in cycle N+1..N+2. That is 2 edges with the FIFO empty.
- Throughput: 1 sample/cycle sustained when out_ready is held high.
- Backpressure: with out_ready low, at most DEPTH samples are held. in_ready drops in the cycle the total reaches DEPTH, and rises the cycle after a read.

## Configuration
- FFT_TX_STATS_EN defined:
  - sat_count increments by 1 for each stage operation where re or im saturated. Both saturating in one sample counts once.
  - The counter holds at 0xFFFF.
- Not defined: sat_count is tied to 0 and no counter logic is built. All other behaviour is identical.

## Test plan
- Reset, then point=3, shift=0, ifft=0, 8 samples re=k, im=−k, out_ready=1 → outputs re=k, im=−k. First out_valid 2 edges after first accept; out_last only on 8th; 8 tx_done pulses.
- shift=4, in_re=0x000018 (24) → out_re=2 (24/16 = 1.5 rounds up). in_re=−24 → out_re=−1. in_re=0x7FFFFF → 32767; with FFT_TX_STATS_EN, sat_count=1.
- ifft=1, shift=8, in_im=−0x800000 → stage saturates to −32768, conjugate → out_im=32767. in_im=0x000100 → out_im=−1.
- out_ready=0, in_valid=1 continuously → exactly DEPTH (4) accepts, then in_ready=0. Raise out_ready → order preserved, no loss or duplication.
- Change cont_point from 3 to 2 after 3rd sample of frame → out_last still on 8th sample. Next frame uses length 4.
- Assert rst_n=0 with 3 samples buffered → out_valid=0 next cycle, in_ready=1, sat_count=0. New frame's last is at the correct count.
